// File: rtl/div_seq_pkg.sv
// Shared CPU header for the sequential divider: datapath widths, FSM encoding
// and the operand payload latched from the execute stage.
package div_seq_pkg;

    localparam int unsigned DIV_W     = 32;
    localparam int unsigned DIV_ITER  = DIV_W;
    localparam int unsigned DIV_CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

    // Operands as handed over by the execute stage; y is reused to hold |y|.
    typedef struct packed {
        logic             signed_op;
        logic [DIV_W-1:0] x;
        logic [DIV_W-1:0] y;
    } div_op_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on the packed {remainder, quotient} register.
module div_step
    import div_seq_pkg::*;
(
    input  logic [2*DIV_W-1:0] rem_in,
    input  logic [DIV_W-1:0]   y_abs,
    output logic [2*DIV_W-1:0] rem_out
);

    logic [DIV_W:0]   top;
    logic [DIV_W-1:0] diff;
    logic             ge;

    // Upper 33 bits of the register after the left shift.
    assign top  = rem_in[2*DIV_W-1:DIV_W-1];
    assign ge   = (top >= {1'b0, y_abs});
    assign diff = top[DIV_W-1:0] - y_abs;

    assign rem_out = {(ge ? diff : top[DIV_W-1:0]), rem_in[DIV_W-2:0], ge};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned 32-bit divider for the execute stage:
// PREP (abs values), 32 restoring iterations, FIX (signs), DONE pulse.
module div_seq
    import div_seq_pkg::div_state_e, div_seq_pkg::div_op_t, div_seq_pkg::DIV_CNT_W,
           div_seq_pkg::IDLE, div_seq_pkg::PREP, div_seq_pkg::ITER,
           div_seq_pkg::FIX, div_seq_pkg::DONE;
#(
    parameter int unsigned DIV_W    = div_seq_pkg::DIV_W,
    parameter int unsigned DIV_ITER = div_seq_pkg::DIV_ITER
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_req,
    input  logic             div_signed,
    input  logic [DIV_W-1:0] div_x,
    input  logic [DIV_W-1:0] div_y,
    input  logic             div_cancel,
    output logic             div_busy,
    output logic             div_done,
    output logic [DIV_W-1:0] div_q,
    output logic [DIV_W-1:0] div_r
);

    div_state_e             state_q, state_d;
    logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
    div_op_t                op_q, op_d;
    logic [2*DIV_W-1:0]     rem_q, rem_d, step_rem;
    logic                   q_neg_q, q_neg_d;
    logic                   r_neg_q, r_neg_d;
    logic                   dz_q, dz_d;
    logic                   busy_d, done_d;
    logic [DIV_W-1:0]       q_d, r_d;
    logic [DIV_W-1:0]       neg_a_in, neg_a, neg_b_in, neg_b, x_abs, y_abs;

    // Two negate adders: |x|,|y| in PREP, then -q,-r in FIX.
    assign neg_a_in = (state_q == FIX) ? rem_q[DIV_W-1:0]       : op_q.x;
    assign neg_b_in = (state_q == FIX) ? rem_q[2*DIV_W-1:DIV_W] : op_q.y;
    assign neg_a    = -neg_a_in;
    assign neg_b    = -neg_b_in;
    assign x_abs    = (op_q.signed_op && op_q.x[DIV_W-1]) ? neg_a : op_q.x;
    assign y_abs    = (op_q.signed_op && op_q.y[DIV_W-1]) ? neg_b : op_q.y;

    div_step u_step (
        .rem_in  (rem_q),
        .y_abs   (op_q.y),
        .rem_out (step_rem)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a flush returns any active operation to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (div_req && !div_cancel) state_d = PREP;
            PREP:    state_d = ITER;
            ITER:    if (cnt_q == DIV_CNT_W'(DIV_ITER - 1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (div_cancel && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // Datapath and output next values.
    always_comb begin
        op_d    = op_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        q_d     = div_q;
        r_d     = div_r;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        unique case (state_q)
            IDLE: begin
                if (div_req && !div_cancel) begin
                    op_d.signed_op = div_signed;
                    op_d.x         = div_x;
                    op_d.y         = div_y;
                end
            end
            PREP: begin
                rem_d   = {DIV_W'(0), x_abs};
                op_d.y  = y_abs;
                q_neg_d = op_q.signed_op && (op_q.x[DIV_W-1] ^ op_q.y[DIV_W-1]);
                r_neg_d = op_q.signed_op && op_q.x[DIV_W-1];
                dz_d    = (op_q.y == '0);
                cnt_d   = '0;
            end
            ITER: begin
                rem_d = step_rem;
                cnt_d = cnt_q + DIV_CNT_W'(1);
            end
            FIX: begin
                if (!div_cancel) begin
                    if (dz_q) begin
                        q_d = '1;
                        r_d = op_q.x;
                    end else begin
                        q_d = q_neg_q ? neg_a : rem_q[DIV_W-1:0];
                        r_d = r_neg_q ? neg_b : rem_q[2*DIV_W-1:DIV_W];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            op_q     <= '0;
            rem_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
            div_busy <= 1'b0;
            div_done <= 1'b0;
            div_q    <= '0;
            div_r    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            dz_q     <= dz_d;
            div_busy <= busy_d;
            div_done <= done_d;
            div_q    <= q_d;
            div_r    <= r_d;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed divisions, cancel and reset cases.
module tb_div_seq;

    logic        clk;
    logic        resetn;
    logic        div_req;
    logic        div_signed;
    logic [31:0] div_x;
    logic [31:0] div_y;
    logic        div_cancel;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [31:0] last_q   = '0;
    logic [31:0] last_r   = '0;

    div_seq dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_req    (div_req),
        .div_signed (div_signed),
        .div_x      (div_x),
        .div_y      (div_y),
        .div_cancel (div_cancel),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .div_q      (div_q),
        .div_r      (div_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every completion pulse must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && div_done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(div_done), 64'(0));
            end else begin
                e = sb.pop_front();
                check("quotient", 64'(div_q), 64'(e.q));
                check("remainder", 64'(div_r), 64'(e.r));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (div_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_wait", 64'(div_busy), 64'(0));
    endtask

    // Called one time unit after a rising edge; accept happens on the next edge.
    task automatic issue(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eq, input logic [31:0] er);
        wait_idle();
        div_req = 1'b1; div_signed = sgn; div_x = x; div_y = y;
        sb.push_back('{eq, er, cyc + 35});
        last_q = eq; last_r = er;
        @(posedge clk); #1;
        div_req = 1'b0; div_x = '0; div_y = '0; div_signed = 1'b0;
    endtask

    // Flush k cycles after accept-drive; only a flush in DONE still completes.
    task automatic issue_cancel(input int k, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] eq, input logic [31:0] er,
                                input logic completes);
        wait_idle();
        div_req = 1'b1; div_signed = 1'b0; div_x = x; div_y = y;
        if (completes) begin
            sb.push_back('{eq, er, cyc + 35});
            last_q = eq; last_r = er;
        end
        @(posedge clk); #1;
        div_req = 1'b0;
        repeat (k - 1) @(posedge clk);
        #1;
        check("busy_before_cancel", 64'(div_busy), 64'(1));
        div_cancel = 1'b1;
        @(posedge clk); #1;
        div_cancel = 1'b0;
        check("busy_after_cancel", 64'(div_busy), 64'(0));
        check("q_after_cancel", 64'(div_q), 64'(last_q));
        check("r_after_cancel", 64'(div_r), 64'(last_r));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        int n;
        resetn = 1'b0; div_req = 1'b0; div_signed = 1'b0;
        div_x = '0; div_y = '0; div_cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(div_busy), 64'(0));
        check("reset_done", 64'(div_done), 64'(0));
        check("reset_q", 64'(div_q), 64'(0));
        check("reset_r", 64'(div_r), 64'(0));
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        // 100/7 with busy window: 35 busy cycles, then idle.
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        nb = 0;
        for (int i = 0; i < 36; i++) begin
            if (div_busy) nb++;
            @(posedge clk); #1;
        end
        check("busy_cycles", 64'(nb), 64'(35));

        issue(1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF);
        issue(1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        issue(1'b0, 32'h0000_1234, 32'd0,        32'hFFFF_FFFF, 32'h0000_1234);
        issue(1'b1, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF9);
        issue(1'b0, 32'hFFFF_FFFF, 32'h10,       32'h0FFF_FFFF, 32'hF);
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);
        issue(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,       32'hFFFF_FFFE);

        // Flush on the 10th ITER cycle, then a new request the next cycle.
        issue_cancel(11, 32'd500, 32'd3, 32'd0, 32'd0, 1'b0);
        issue(1'b0, 32'd500, 32'd3, 32'd166, 32'd2);
        // Flush in FIX: no completion, results untouched.
        issue_cancel(34, 32'd81, 32'd9, 32'd0, 32'd0, 1'b0);
        // Flush in DONE: completion already committed.
        issue_cancel(35, 32'd81, 32'd8, 32'd10, 32'd1, 1'b1);

        // Request and flush together in IDLE: flush wins.
        wait_idle();
        div_req = 1'b1; div_cancel = 1'b1; div_x = 32'd9; div_y = 32'd3;
        @(posedge clk); #1;
        div_req = 1'b0; div_cancel = 1'b0;
        check("req_cancel_idle_busy", 64'(div_busy), 64'(0));

        // Request held through a whole operation is accepted once.
        wait_idle();
        div_req = 1'b1; div_signed = 1'b0; div_x = 32'd1000; div_y = 32'd7;
        sb.push_back('{32'd142, 32'd6, cyc + 35});
        last_q = 32'd142; last_r = 32'd6;
        n = 0;
        while (!div_done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("held_req_done", 64'(div_done), 64'(1));
        div_req = 1'b0;
        @(posedge clk); #1;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (div_busy) nb++;
        end
        check("held_req_single", 64'(nb), 64'(0));

        // Asynchronous reset in the middle of ITER.
        wait_idle();
        div_req = 1'b1; div_signed = 1'b0; div_x = 32'd55; div_y = 32'd5;
        @(posedge clk); #1;
        div_req = 1'b0;
        repeat (14) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check("arst_busy", 64'(div_busy), 64'(0));
        check("arst_done", 64'(div_done), 64'(0));
        check("arst_q", 64'(div_q), 64'(0));
        check("arst_r", 64'(div_r), 64'(0));
        last_q = '0; last_r = '0;
        @(posedge clk); #3 resetn = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("sb_drain", 64'(sb.size()), 64'(0));
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
